cust_hp_filter: RTL and testbench

- Streaming first-order IIR high-pass (DC-offset removal) filter for multiplexed amplifier channels in the stimulation-controller datapath.
- Each input sample carries a channel number; the block keeps one low-pass state per channel and outputs the sample minus its tracked DC level, tagged with the same channel number.
- Valid/read handshakes on both sides; throughput one sample per clock.

---
 rtl/cust_hp_filter.sv | 99 +++++++++
 tb/tb_cust_hp_filter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cust_hp_filter.sv
// cust_hp_filter: streaming first-order IIR high-pass (DC-offset removal)
// for multiplexed channels. One Q16.16 low-pass accumulator is kept per
// channel; each accepted sample is output minus its tracked DC level after
// one clock, tagged with its channel number. Channel numbers at or above
// CHANNELS pass through unchanged and touch no state.
module cust_hp_filter #(
    parameter int CHANNELS     = 1,
    parameter int CHANNELS_PW2 = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [15:0]        chan_in_sample,
    input  logic [CHANNELS_PW2-1:0]   chan_in_num,
    input  logic                      chan_in_valid,
    output logic                      chan_in_read,
    output logic signed [15:0]        chan_out_sample,
    output logic [CHANNELS_PW2-1:0]   chan_out_num,
    output logic                      chan_out_valid,
    input  logic                      chan_out_read,
    input  logic [15:0]               coeff
);

    logic signed [31:0] acc [CHANNELS];

    logic               accept;
    logic               hit;
    logic signed [15:0] lp;
    logic signed [16:0] diff;
    logic signed [15:0] diff_sat;
    logic signed [31:0] diff_ext;
    logic signed [31:0] coeff_ext;
    logic signed [31:0] product;
    logic signed [15:0] result;

    // The single output slot can take a new sample whenever it is empty or
    // being drained in this same cycle.
    assign chan_in_read = !chan_out_valid || chan_out_read;
    assign accept       = chan_in_valid && chan_in_read;

    // Look up the addressed channel's DC estimate with a compare loop so that
    // out-of-range channel numbers simply miss instead of aliasing an entry.
    always_comb begin
        hit = 1'b0;
        lp  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (chan_in_num == CHANNELS_PW2'(c)) begin
                hit = 1'b1;
                lp  = acc[c][31:16];
            end
        end
    end

    // Difference, clamp to 16 bits, and the accumulator increment. The 32-bit
    // product only needs its low bits: alpha < 1 keeps the sum in range.
    always_comb begin
        diff      = {chan_in_sample[15], chan_in_sample} - {lp[15], lp};
        diff_sat  = diff[15:0];
        if (diff[16] != diff[15]) begin
            diff_sat = diff[16] ? 16'sh8000 : 16'sh7fff;
        end
        diff_ext  = 32'(diff);
        coeff_ext = $signed({16'h0000, coeff});
        product   = diff_ext * coeff_ext;
        result    = hit ? diff_sat : chan_in_sample;
    end

    // Per-channel low-pass state: only the addressed in-range channel moves,
    // and only on an accepted sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
            end
        end else if (accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (chan_in_num == CHANNELS_PW2'(c)) begin
                    acc[c] <= acc[c] + product;
                end
            end
        end
    end

    // Output slot: load on accept (replacing a sample drained this cycle),
    // empty on drain alone, otherwise hold steady.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chan_out_sample <= '0;
            chan_out_num    <= '0;
            chan_out_valid  <= 1'b0;
        end else if (accept) begin
            chan_out_sample <= result;
            chan_out_num    <= chan_in_num;
            chan_out_valid  <= 1'b1;
        end else if (chan_out_read) begin
            chan_out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cust_hp_filter.sv
// tb_cust_hp_filter: directed checks of cust_hp_filter built with two
// channels: reset, step response, backpressure, saturation, channel
// independence and out-of-range pass-through.
module tb_cust_hp_filter;

    localparam int CH = 2;
    localparam int PW = 7;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic signed [15:0] chan_in_sample = '0;
    logic [PW-1:0]      chan_in_num = '0;
    logic               chan_in_valid = 1'b0;
    logic               chan_in_read;
    logic signed [15:0] chan_out_sample;
    logic [PW-1:0]      chan_out_num;
    logic               chan_out_valid;
    logic               chan_out_read = 1'b0;
    logic [15:0]        coeff = '0;

    int checks = 0;
    int errors = 0;

    int indep_x   [5] = '{5000, -3000, 5000, -3000, 5000};
    int indep_num [5] = '{0, 1, 0, 1, 0};
    int indep_exp [5] = '{5000, -3000, 1, 0, 0};

    logic signed [31:0] prev;

    cust_hp_filter #(.CHANNELS(CH), .CHANNELS_PW2(PW)) dut (
        .clk             (clk),
        .reset           (reset),
        .chan_in_sample  (chan_in_sample),
        .chan_in_num     (chan_in_num),
        .chan_in_valid   (chan_in_valid),
        .chan_in_read    (chan_in_read),
        .chan_out_sample (chan_out_sample),
        .chan_out_num    (chan_out_num),
        .chan_out_valid  (chan_out_valid),
        .chan_out_read   (chan_out_read),
        .coeff           (coeff)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic signed [31:0] got,
                                input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_slot(input string tag, input logic v, input int x, input int num);
        check_output({tag, " valid"}, 32'(chan_out_valid), 32'(v));
        check_output({tag, " sample"}, 32'(chan_out_sample), x);
        check_output({tag, " num"}, 32'(chan_out_num), num);
    endtask

    task automatic apply_stimulus(input int x, input int num, input logic v, input logic r);
        chan_in_sample = 16'(x);
        chan_in_num    = PW'(num);
        chan_in_valid  = v;
        chan_out_read  = r;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        apply_stimulus(0, 0, 1'b0, 1'b1);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        // Power-on reset
        #12;
        check_slot("por", 1'b0, 0, 0);
        reset = 1'b1;
        #1;
        check_output("por in_read", 32'(chan_in_read), 1);
        tick();

        // Reset mid-stream clears slot and state
        coeff = 16'd65535;
        apply_stimulus(1234, 1, 1'b1, 1'b1);
        tick();
        check_slot("pre-reset", 1'b1, 1234, 1);
        apply_stimulus(1234, 0, 1'b1, 1'b1);
        tick();
        apply_stimulus(0, 0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check_slot("mid reset", 1'b0, 0, 0);
        #3;
        reset = 1'b1;
        tick();
        check_output("post reset in_read", 32'(chan_in_read), 1);
        coeff = 16'd10;
        apply_stimulus(1234, 0, 1'b1, 1'b1);
        tick();
        check_slot("cleared state", 1'b1, 1234, 0);

        // Step response: seven full-height outputs, then the DC estimate moves
        do_reset();
        coeff = 16'd10;
        apply_stimulus(1000, 0, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_output($sformatf("step out %0d", i), 32'(chan_out_sample),
                         (i < 8) ? 1000 : 999);
        end
        prev = 999;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_output("decay valid", 32'(chan_out_valid), 1);
            check_output("decay nonincreasing", 32'(chan_out_sample <= prev), 1);
            prev = 32'(chan_out_sample);
        end
        apply_stimulus(0, 0, 1'b0, 1'b1);
        tick();
        check_output("drain valid", 32'(chan_out_valid), 0);

        // Backpressure: slot frozen, input blocked until read returns
        do_reset();
        coeff = 16'd10;
        apply_stimulus(1000, 0, 1'b1, 1'b0);
        tick();
        check_slot("bp first", 1'b1, 1000, 0);
        check_output("bp in_read low", 32'(chan_in_read), 0);
        apply_stimulus(500, 1, 1'b1, 1'b0);
        tick();
        tick();
        check_slot("bp held", 1'b1, 1000, 0);
        check_output("bp still blocked", 32'(chan_in_read), 0);
        apply_stimulus(500, 1, 1'b1, 1'b1);
        #1;
        check_output("bp in_read high", 32'(chan_in_read), 1);
        tick();
        check_slot("bp accepted", 1'b1, 500, 1);
        apply_stimulus(0, 0, 1'b0, 1'b1);
        tick();
        check_output("bp drained", 32'(chan_out_valid), 0);

        // Channel independence with alpha near one
        do_reset();
        coeff = 16'd65535;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(indep_x[i], indep_num[i], 1'b1, 1'b1);
            tick();
            check_slot($sformatf("indep %0d", i), 1'b1, indep_exp[i], indep_num[i]);
        end

        // Saturation with a preloaded DC level and frozen state
        do_reset();
        coeff = 16'd65535;
        apply_stimulus(-20000, 1, 1'b1, 1'b1);
        tick();
        check_slot("sat preload ch1", 1'b1, -20000, 1);
        coeff = 16'd0;
        apply_stimulus(32767, 1, 1'b1, 1'b1);
        tick();
        check_slot("sat positive", 1'b1, 32767, 1);
        apply_stimulus(-32768, 1, 1'b1, 1'b1);
        tick();
        check_slot("frozen ch1", 1'b1, -12768, 1);
        coeff = 16'd65535;
        apply_stimulus(20000, 0, 1'b1, 1'b1);
        tick();
        check_slot("sat preload ch0", 1'b1, 20000, 0);
        coeff = 16'd0;
        apply_stimulus(-32768, 0, 1'b1, 1'b1);
        tick();
        check_slot("sat negative", 1'b1, -32768, 0);

        // Out-of-range channels pass through and leave state alone
        do_reset();
        coeff = 16'd65535;
        apply_stimulus(1000, 0, 1'b1, 1'b1);
        tick();
        check_slot("oor preload", 1'b1, 1000, 0);
        apply_stimulus(777, 2, 1'b1, 1'b1);
        tick();
        check_slot("oor ch2", 1'b1, 777, 2);
        apply_stimulus(-777, 5, 1'b1, 1'b1);
        tick();
        check_slot("oor ch5", 1'b1, -777, 5);
        coeff = 16'd0;
        apply_stimulus(999, 0, 1'b1, 1'b1);
        tick();
        check_slot("oor ch0 intact", 1'b1, 0, 0);
        apply_stimulus(0, 0, 1'b0, 1'b1);
        tick();
        check_output("final drain", 32'(chan_out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
